// File: rtl/move_anim_sequencer_if.sv
// Request/display bundle between the game controller (master) and the token animation sequencer (slave).
interface move_anim_sequencer_if;
  logic       pos_valid;
  logic       event_req;
  logic [3:0] p1_target;
  logic [3:0] p2_target;
  logic [3:0] anim_p1_pos;
  logic [3:0] anim_p2_pos;
  logic       moving_player;
  logic       busy;
  logic       turn_done;

  modport master (
    output pos_valid, event_req, p1_target, p2_target,
    input  anim_p1_pos, anim_p2_pos, moving_player, busy, turn_done
  );

  modport slave (
    input  pos_valid, event_req, p1_target, p2_target,
    output anim_p1_pos, anim_p2_pos, moving_player, busy, turn_done
  );
endinterface

// File: rtl/move_anim_sequencer.sv
// Walks both board tokens one square per step toward the committed targets and
// returns a one-cycle turn_done when a move, zero-move acknowledge or event hold ends.
module move_anim_sequencer #(
  parameter int STEP_CYCLES     = 25_000_000,
  parameter int EVT_HOLD_CYCLES = 50_000_000,
  parameter int MAX_POS         = 10
) (
  input logic                  clk,
  input logic                  reset_n,
  move_anim_sequencer_if.slave seq
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_MOVE     = 2'd1;
  localparam logic [1:0] S_EVT_HOLD = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  localparam int STEP_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int HOLD_W = (EVT_HOLD_CYCLES > 1) ? $clog2(EVT_HOLD_CYCLES) : 1;
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(EVT_HOLD_CYCLES - 1);
  localparam logic [3:0]        MAX_P     = 4'(MAX_POS);

  logic [1:0]        state_q, state_d;
  logic [3:0]        p1_pos_q, p1_pos_d;
  logic [3:0]        p2_pos_q, p2_pos_d;
  logic              mp_q, mp_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              pv_pend_q, pv_pend_d;
  logic              ev_pend_q, ev_pend_d;
  logic              pv_prev_q, ev_prev_q;

  logic [3:0] eff1, eff2;
  logic [3:0] p1_step, p2_step;
  logic       mis1, mis2;
  logic       pv_rise, ev_rise;

  assign eff1 = (seq.p1_target > MAX_P) ? MAX_P : seq.p1_target;
  assign eff2 = (seq.p2_target > MAX_P) ? MAX_P : seq.p2_target;
  assign mis1 = (eff1 != p1_pos_q);
  assign mis2 = (eff2 != p2_pos_q);

  // Only used while the token mismatches, so the decrement never wraps below 0.
  assign p1_step = (p1_pos_q < eff1) ? p1_pos_q + 4'd1 : p1_pos_q - 4'd1;
  assign p2_step = (p2_pos_q < eff2) ? p2_pos_q + 4'd1 : p2_pos_q - 4'd1;

  assign pv_rise = seq.pos_valid & ~pv_prev_q;
  assign ev_rise = seq.event_req & ~ev_prev_q;

  always_comb begin
    state_d    = state_q;
    p1_pos_d   = p1_pos_q;
    p2_pos_d   = p2_pos_q;
    mp_d       = mp_q;
    step_cnt_d = step_cnt_q;
    hold_cnt_d = hold_cnt_q;
    pv_pend_d  = pv_pend_q | pv_rise;
    ev_pend_d  = ev_pend_q | ev_rise;

    case (state_q)
      S_IDLE: begin
        if (mis1 || mis2) begin
          state_d    = S_MOVE;
          mp_d       = ~mis1;
          step_cnt_d = '0;
        end else if (pv_pend_q) begin
          state_d = S_DONE;
        end else if (ev_pend_q) begin
          state_d    = S_EVT_HOLD;
          hold_cnt_d = '0;
        end
      end

      S_MOVE: begin
        if (!mis1 && !mis2) begin
          state_d = S_DONE;
        end else if (mp_q && mis1) begin
          // A retarget of player 1 during player 2's walk hands the step back to player 1.
          mp_d       = 1'b0;
          step_cnt_d = '0;
        end else if (!mp_q && !mis1) begin
          mp_d       = 1'b1;
          step_cnt_d = '0;
        end else if (step_cnt_q == STEP_LAST) begin
          step_cnt_d = '0;
          if (!mp_q) begin
            p1_pos_d = p1_step;
            // Hand over on the landing step itself so player 2 starts without a dead cycle.
            if ((p1_step == eff1) && mis2) begin
              mp_d = 1'b1;
            end
          end else begin
            p2_pos_d = p2_step;
          end
        end else begin
          step_cnt_d = step_cnt_q + 1'b1;
        end
      end

      S_EVT_HOLD: begin
        if (mis1 || mis2) begin
          state_d    = S_MOVE;
          mp_d       = ~mis1;
          step_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d = S_DONE;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      S_DONE: begin
        // One pulse acknowledges every request pending so far, including edges seen this cycle.
        pv_pend_d = 1'b0;
        ev_pend_d = 1'b0;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      p1_pos_q   <= '0;
      p2_pos_q   <= '0;
      mp_q       <= 1'b0;
      step_cnt_q <= '0;
      hold_cnt_q <= '0;
      pv_pend_q  <= 1'b0;
      ev_pend_q  <= 1'b0;
      pv_prev_q  <= 1'b0;
      ev_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      p1_pos_q   <= p1_pos_d;
      p2_pos_q   <= p2_pos_d;
      mp_q       <= mp_d;
      step_cnt_q <= step_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      pv_pend_q  <= pv_pend_d;
      ev_pend_q  <= ev_pend_d;
      pv_prev_q  <= seq.pos_valid;
      ev_prev_q  <= seq.event_req;
    end
  end

  assign seq.anim_p1_pos   = p1_pos_q;
  assign seq.anim_p2_pos   = p2_pos_q;
  assign seq.moving_player = mp_q;
  assign seq.busy          = (state_q != S_IDLE);
  assign seq.turn_done     = (state_q == S_DONE);

endmodule

// File: tb/tb_move_anim_sequencer.sv
// Randomized and directed checks of move_anim_sequencer against a timeline model
// derived from square distances, step period and hold period.
module tb_move_anim_sequencer;
  localparam int S   = 4;
  localparam int H   = 6;
  localparam int MAX = 10;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;
  int   cur1;
  int   cur2;
  int   txn;

  move_anim_sequencer_if sif ();

  move_anim_sequencer #(
    .STEP_CYCLES(S),
    .EVT_HOLD_CYCLES(H),
    .MAX_POS(MAX)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .seq(sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int t);
    return (t > MAX) ? MAX : t;
  endfunction

  function automatic int absi(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // Caller is positioned just after a rising edge; inputs applied now form cycle 0.
  task automatic run_move(input int t1, input int t2, input bit pv, input bit ev);
    int e1, e2, d1, d2, dt, done_c, busy_start, last_c, dones, steps, s1, s2, ep1, ep2, emp;
    e1 = clampi(t1);
    e2 = clampi(t2);
    d1 = absi(e1 - cur1);
    d2 = absi(e2 - cur2);
    dt = d1 + d2;
    if (dt > 0)   done_c = 2 + dt * S;
    else if (pv)  done_c = 2;
    else if (ev)  done_c = 2 + H;
    else          done_c = -1;
    busy_start = (dt > 0) ? 1 : 2;
    last_c = ((done_c > 0) ? done_c : 2) + 3;
    sif.p1_target = 4'(t1);
    sif.p2_target = 4'(t2);
    sif.pos_valid = pv;
    sif.event_req = ev;
    dones = 0;
    for (int c = 1; c <= last_c; c++) begin
      @(posedge clk);
      #1;
      steps = (c - 1) / S;
      if (steps > dt) steps = dt;
      s1 = (steps < d1) ? steps : d1;
      s2 = steps - s1;
      ep1 = cur1 + ((e1 >= cur1) ? s1 : -s1);
      ep2 = cur2 + ((e2 >= cur2) ? s2 : -s2);
      check_eq($sformatf("t%0d pos1@%0d", txn, c), int'(sif.anim_p1_pos), ep1);
      check_eq($sformatf("t%0d pos2@%0d", txn, c), int'(sif.anim_p2_pos), ep2);
      check_eq($sformatf("t%0d done@%0d", txn, c), int'(sif.turn_done), (c == done_c) ? 1 : 0);
      check_eq($sformatf("t%0d busy@%0d", txn, c), int'(sif.busy),
               (done_c > 0 && c >= busy_start && c <= done_c) ? 1 : 0);
      if (dt > 0 && c < done_c) begin
        emp = (d1 > 0 && c < 1 + d1 * S) ? 0 : ((d2 > 0) ? 1 : 0);
        check_eq($sformatf("t%0d mp@%0d", txn, c), int'(sif.moving_player), emp);
      end
      if (sif.turn_done) dones++;
    end
    check_eq($sformatf("t%0d done_count", txn), dones, (done_c > 0) ? 1 : 0);
    $display("txn %0d: p1 %0d->%0d p2 %0d->%0d pv=%0d ev=%0d turn_done_cycle=%0d",
             txn, cur1, e1, cur2, e2, pv, ev, done_c);
    sif.pos_valid = 1'b0;
    sif.event_req = 1'b0;
    cur1 = e1;
    cur2 = e2;
    txn++;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Event hold interrupted at hold cycle 3 by a one-square player-1 retarget.
  task automatic hold_abandon();
    int nt, dones, done_at, exp_done;
    nt = (cur1 < MAX) ? cur1 + 1 : cur1 - 1;
    exp_done = 5 + 2 + S;
    sif.event_req = 1'b1;
    dones = 0;
    done_at = -1;
    for (int c = 1; c <= exp_done + 3; c++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("abandon busy@%0d", c), int'(sif.busy), (c >= 2 && c <= exp_done) ? 1 : 0);
      check_eq($sformatf("abandon pos1@%0d", c), int'(sif.anim_p1_pos), (c >= exp_done - 1) ? nt : cur1);
      if (sif.turn_done) begin
        dones++;
        done_at = c;
      end
      if (c == 5) sif.p1_target = 4'(nt);
    end
    check_eq("abandon done_count", dones, 1);
    check_eq("abandon done_cycle", done_at, exp_done);
    $display("txn %0d: hold abandoned, p1 %0d->%0d turn_done_cycle=%0d", txn, cur1, nt, done_at);
    sif.event_req = 1'b0;
    cur1 = nt;
    txn++;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cur1 = 0;
    cur2 = 0;
    txn = 0;
    reset_n = 1'b0;
    sif.p1_target = 4'd5;
    sif.p2_target = 4'd0;
    sif.pos_valid = 1'b0;
    sif.event_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset pos1", int'(sif.anim_p1_pos), 0);
    check_eq("reset busy", int'(sif.busy), 0);
    check_eq("reset done", int'(sif.turn_done), 0);
    reset_n = 1'b1;
    run_move(5, 0, 1'b0, 1'b0);

    run_move(5, 3, 1'b0, 1'b0);
    run_move(5, 0, 1'b0, 1'b1);

    run_move(10, 0, 1'b0, 1'b0);
    run_move(12, 0, 1'b1, 1'b0);

    run_move(12, 0, 1'b0, 1'b1);
    hold_abandon();

    run_move(5, 1, 1'b0, 1'b0);
    run_move(7, 0, 1'b0, 1'b0);

    // Reset in the middle of a three-square move
    run_move(0, 0, 1'b0, 1'b0);
    sif.p1_target = 4'd3;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
    end
    check_eq("midreset pre pos1", int'(sif.anim_p1_pos), 1);
    reset_n = 1'b0;
    #1;
    check_eq("midreset pos1", int'(sif.anim_p1_pos), 0);
    check_eq("midreset busy", int'(sif.busy), 0);
    check_eq("midreset done", int'(sif.turn_done), 0);
    check_eq("midreset mp", int'(sif.moving_player), 0);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check_eq($sformatf("midreset hold done@%0d", c), int'(sif.turn_done), 0);
    end
    cur1 = 0;
    cur2 = 0;
    reset_n = 1'b1;
    run_move(3, 0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      run_move(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/move_anim_sequencer.md
Name: move_anim_sequencer

Overview:
- Drives the board-display token positions between the game logic controller and the board renderer.
- Walks each player token one square per step toward the position the controller commits. Walks backward on the go-back-to-start event.
- Returns a single-cycle `turn_done` handshake when the animation ends, or when a zero-move or event hold ends. The controller uses it to leave its wait-for-animation and start-event states.

Parameters:
- STEP_CYCLES, 25_000_000, clock cycles per one-square step (0.25 s at 100 MHz).
- EVT_HOLD_CYCLES, 50_000_000, display hold time for events that do not move a token.
- MAX_POS, 10, last board square; targets above it are clamped.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- pos_valid  in  1  level; high while the controller is waiting for the move animation.
- event_req  in  1  level; high while the controller is waiting for event handling.
- p1_target  in  4  committed player-1 position.
- p2_target  in  4  committed player-2 position.
- anim_p1_pos  out  4  displayed player-1 square.
- anim_p2_pos  out  4  displayed player-2 square.
- moving_player  out  1  0 = player 1 is stepping, 1 = player 2 is stepping.
- busy  out  1  high in any state other than S_IDLE.
- turn_done  out  1  one-cycle completion pulse.

Behaviour:
- **Reset.** On reset_n low, asynchronously:
  - state = S_IDLE;
  - anim_p1_pos = anim_p2_pos = 0;
  - moving_player = 0, busy = 0, turn_done = 0;
  - step counter = 0, hold counter = 0;
  - pending flags = 0;
  - edge-detect registers = 0.
  Reset in the middle of a step or hold abandons it; no turn_done is issued.
- **Clamping.** Effective target = min(target, MAX_POS). All comparisons use the 4-bit unsigned effective target.
- **Mismatch.** mis1 = (eff_p1 != anim_p1_pos). mis2 = (eff_p2 != anim_p2_pos).
- **Edge latching.**
  - A rising edge of pos_valid (previous value 0, current 1) sets pv_pend.
  - A rising edge of event_req sets ev_pend.
  - Edges are latched in every state.
- **State machine.** States: S_IDLE, S_MOVE, S_EVT_HOLD, S_DONE.
- **S_IDLE**, evaluated in priority order:
  - mis1 or mis2 → S_MOVE. moving_player = mis1 ? 0 : 1. Counter = 0.
  - else pv_pend → S_DONE (zero-move acknowledge, e.g. a clamped move at MAX_POS).
  - else ev_pend → S_EVT_HOLD. Hold counter = 0.
- **S_MOVE:**
  - Counter increments each cycle.
  - At counter == STEP_CYCLES-1, the selected token moves one square toward its target (+1 if below, -1 if above), and the counter returns to 0.
  - Mismatch is re-evaluated every cycle, so a target change during a move retargets without restarting.
  - Player 1 is always finished before player 2.
  - When the selected player matches and the other player mismatches, moving_player switches and the counter resets.
  - When neither player mismatches → S_DONE.
- **S_EVT_HOLD:**
  - Counts EVT_HOLD_CYCLES; then → S_DONE.
  - If a mismatch appears during the hold → S_MOVE immediately, and the hold is abandoned.
- **S_DONE:**
  - turn_done = 1 for exactly this one cycle.
  - Clears pv_pend and ev_pend (one pulse serves all pending requests).
  - → S_IDLE.
- **Latency.**
  - A target change visible at cycle 0 with a k-square move:
    - busy rises at cycle 1;
    - square j is displayed at cycle 1 + j·STEP_CYCLES;
    - turn_done is high at cycle 2 + k·STEP_CYCLES.
  - An event_req edge at cycle 0 with no mismatch gives turn_done at cycle 2 + EVT_HOLD_CYCLES.
  - A pos_valid edge with no mismatch gives turn_done at cycle 2.
- **Simultaneous events.**
  - A target change together with an event_req edge produces one move followed by one turn_done; ev_pend is consumed by that turn_done.
  - An edge arriving in the S_DONE cycle is cleared by that same cycle. The level source re-asserts only on the next controller visit.
- **Widths.** Positions never leave 0..MAX_POS. Step arithmetic is 4-bit, with no wrap possible.

Test Plan:
- Run with STEP_CYCLES=4, EVT_HOLD_CYCLES=6.
- Reset: hold reset_n=0 with p1_target=5 → anim_p1_pos=0, busy=0, turn_done=0. Release → anim_p1_pos steps 1..5 at cycles 5, 9, 13, 17, 21 → turn_done pulse at cycle 22, one cycle wide.
- Go-back event: anim_p2_pos=3, set p2_target=0 and raise event_req in the same cycle → anim_p2_pos goes 2, 1, 0 at 4-cycle intervals → exactly one turn_done at cycle 14; busy low afterward.
- Zero move: p1_target=12 (clamped to 10) while anim_p1_pos=10, raise pos_valid → turn_done at cycle 2; anim_p1_pos stays 10.
- Event hold: event_req rises with no mismatch → busy high for 7 cycles → turn_done at cycle 8. Repeat with p1_target changed at hold cycle 3 → the hold is abandoned, the move runs, and a single turn_done follows the move.
- Dual mismatch: p1 +2 and p2 -1 simultaneously → moving_player=0 for 8 cycles, then 1 for 4 cycles → a single turn_done at cycle 14.
- Mid-step reset: assert reset_n=0 at cycle 6 of a 3-square move → all outputs 0 immediately and no turn_done. After release, the move restarts from anim_p1_pos=0.
